// File: rtl/arb_rr4.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr4
//  Description : Four-requester round-robin arbiter with a bounded hold time.
//                Requests are scanned in rotating priority order starting at
//                a rotation pointer; the first active request wins. The grant
//                is registered (one-hot plus 2-bit index). A current owner
//                that keeps requesting is revoked after MAX_HOLD cycles
//                whenever another requester is waiting, so no client can
//                starve the others.
//
//  Parameters  : MAX_HOLD - max consecutive grant cycles while another
//                           request is pending (0 = never preempt)
//                CW       - hold counter width, 2**CW must exceed MAX_HOLD
//
//  Ports       : clk       in   rising-edge clock
//                reset     in   asynchronous active-high reset
//                en        in   arbitration enable (0 blocks new grants)
//                req[3:0]  in   request vector, held while resource wanted
//                gnt[3:0]  out  registered one-hot grant
//                gnt_id    out  binary index of owner (00 when no grant)
//                gnt_valid out  high whenever gnt is non-zero
//                preempt   out  one-cycle pulse in the cycle a grant is
//                               revoked by hold timeout (combinational)
//
//  Revision    : 1.0 - initial release
// ============================================================================

module arb_rr4 #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Hold count at which a waiting requester may take the resource away.
    localparam logic [CW-1:0] c_hold_max   = CW'(MAX_HOLD);
    // Saturation value of the hold counter. With preemption disabled the
    // counter simply runs up to all-ones and parks there.
    localparam logic [CW-1:0] c_hold_sat   = (MAX_HOLD == 0) ? {CW{1'b1}} : c_hold_max;
    localparam logic          c_timeout_en = (MAX_HOLD != 0);
    localparam logic [CW-1:0] c_hold_one   = CW'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,   // no owner, outputs at zero
        ST_GRANT = 1'b1    // owner is r_gnt_id
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_ptr;
    logic [1:0]    w_ptr_nxt;
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] w_hold_nxt;
    logic [3:0]    r_gnt;
    logic [3:0]    w_gnt_nxt;
    logic [1:0]    r_gnt_id;
    logic [1:0]    w_gnt_id_nxt;
    logic          w_preempt;

    // ------------------------------------------------------------------------
    // Rotating-priority selection.
    // Returns {found, index}: the first set bit of vec when scanning
    // start, start+1, start+2, start+3 (mod 4). The loop runs from the
    // farthest offset down to the nearest so that the nearest set bit is
    // the last assignment and therefore wins.
    // ------------------------------------------------------------------------
    function automatic logic [2:0] f_sel(input logic [1:0] start,
                                         input logic [3:0] vec);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Request views used by the decision logic
    // ------------------------------------------------------------------------
    logic [3:0] w_owner_oh;     // one-hot of current owner
    logic [3:0] w_others;       // requests excluding the current owner
    logic [1:0] w_rot;          // index just after the owner
    logic [2:0] w_sel_idle;     // winner when starting from the pointer
    logic [2:0] w_sel_hand;     // winner for a handover away from the owner
    logic       w_owner_req;    // owner still wants the resource
    logic       w_timeout;      // hold limit reached with someone waiting

    assign w_owner_oh  = 4'b0001 << r_gnt_id;
    assign w_others    = req & ~w_owner_oh;
    assign w_rot       = r_gnt_id + 2'd1;
    assign w_sel_idle  = f_sel(r_ptr, req);
    // The owner's own bit is masked so that a request edge for the owner
    // in the release cycle cannot re-grant it immediately.
    assign w_sel_hand  = f_sel(w_rot, w_others);
    assign w_owner_req = req[r_gnt_id];
    assign w_timeout   = c_timeout_en && (r_hold_cnt == c_hold_max) &&
                         en && (|w_others);

    // ------------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_hold_nxt   = r_hold_cnt;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_preempt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt    = 4'b0000;
                w_gnt_id_nxt = 2'b00;
                w_hold_nxt   = '0;
                if (en && w_sel_idle[2]) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_nxt    = 4'b0001 << w_sel_idle[1:0];
                    w_gnt_id_nxt = w_sel_idle[1:0];
                    w_hold_nxt   = c_hold_one;
                end
            end

            ST_GRANT: begin
                if (!w_owner_req) begin
                    // Release takes precedence over timeout, so preempt
                    // stays low even if the hold limit was also reached.
                    w_ptr_nxt = w_rot;
                    if (en && w_sel_hand[2]) begin
                        // Direct handover, no idle cycle in between.
                        w_gnt_nxt    = 4'b0001 << w_sel_hand[1:0];
                        w_gnt_id_nxt = w_sel_hand[1:0];
                        w_hold_nxt   = c_hold_one;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_gnt_nxt    = 4'b0000;
                        w_gnt_id_nxt = 2'b00;
                        w_hold_nxt   = '0;
                    end
                end else if (w_timeout) begin
                    // w_timeout guarantees a waiting requester, so the
                    // handover selection always finds a winner here.
                    w_preempt    = 1'b1;
                    w_ptr_nxt    = w_rot;
                    w_gnt_nxt    = 4'b0001 << w_sel_hand[1:0];
                    w_gnt_id_nxt = w_sel_hand[1:0];
                    w_hold_nxt   = c_hold_one;
                end else begin
                    // Keep the grant; the counter saturates so that a long
                    // uncontested hold is preempted immediately once a
                    // competitor shows up.
                    if (r_hold_cnt != c_hold_sat) begin
                        w_hold_nxt = r_hold_cnt + c_hold_one;
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_gnt_nxt    = 4'b0000;
                w_gnt_id_nxt = 2'b00;
                w_hold_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'b00;
            r_hold_cnt <= '0;
            r_gnt      <= 4'b0000;
            r_gnt_id   <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = |r_gnt;
    // Gated by state so that the pulse is low in IDLE regardless of
    // how the handover decode is later extended.
    assign preempt   = (r_state == ST_GRANT) && w_preempt;

endmodule

`default_nettype wire

// File: tb/tb_arb_rr4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_rr4
//  Description : Directed self-checking bench for arb_rr4 (MAX_HOLD=4).
//                Inputs change 1 time unit after a rising edge; outputs are
//                sampled at the same point, well away from the next edge.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_arb_rr4;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int n_assert;
    int n_fail;

    arb_rr4 #(
        .MAX_HOLD (4),
        .CW       (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check all four outputs at once.
    task automatic check_out(input string tag, input logic [3:0] e_gnt,
                             input logic [1:0] e_id, input logic e_pre);
        check({tag, "_gnt"},     gnt, e_gnt);
        check({tag, "_id"},      {2'b00, gnt_id}, {2'b00, e_id});
        check({tag, "_valid"},   {3'b000, gnt_valid}, {3'b000, (e_gnt != 4'b0000)});
        check({tag, "_preempt"}, {3'b000, preempt}, {3'b000, e_pre});
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        en       = 1'b0;
        req      = 4'b0000;
        tick();
        tick();
        check_out("reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;

        // ---- 1: single request, one-cycle latency, release to idle
        en  = 1'b1;
        req = 4'b0100;
        tick();
        check_out("t1_grant", 4'b0100, 2'd2, 1'b0);
        req = 4'b0000;
        tick();
        check_out("t1_release", 4'b0000, 2'd0, 1'b0);

        // ---- 2: all requesting, rotation with 4-cycle hold limit
        pulse_reset();
        req = 4'b1111;
        tick();
        for (int c = 0; c < 20; c++) begin
            check_out("t2_rot", 4'b0001 << ((c / 4) % 4), 2'((c / 4) % 4), ((c % 4) == 3));
            tick();
        end

        // ---- 3: owner 1 releases with 3 and 0 waiting -> 3 wins, no bubble
        pulse_reset();
        req = 4'b0010;
        tick();
        check_out("t3_own1", 4'b0010, 2'd1, 1'b0);
        req = 4'b1011;
        tick();
        check_out("t3_hold", 4'b0010, 2'd1, 1'b0);
        req = 4'b1001;
        tick();
        check_out("t3_hand", 4'b1000, 2'd3, 1'b0);

        // ---- 4: lone requester holds 10 cycles, counter saturates
        pulse_reset();
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_out("t4_lone", 4'b0010, 2'd1, 1'b0);
        end
        // Saturated hold count: a new competitor triggers preemption at once.
        req = 4'b1010;
        #1;
        check("t4_sat_preempt", {3'b000, preempt}, 4'b0001);
        tick();
        check_out("t4_after", 4'b1000, 2'd3, 1'b0);

        // ---- 5: en=0 blocks preemption and new grants
        pulse_reset();
        en  = 1'b0;
        req = 4'b1111;
        tick();
        check_out("t5_blocked", 4'b0000, 2'd0, 1'b0);
        en  = 1'b1;
        req = 4'b0100;
        tick();
        check_out("t5_own2", 4'b0100, 2'd2, 1'b0);
        en  = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_out("t5_hold", 4'b0100, 2'd2, 1'b0);
        end
        req = 4'b1011;
        tick();
        check_out("t5_idle", 4'b0000, 2'd0, 1'b0);
        en = 1'b1;
        tick();
        check_out("t5_regrant", 4'b1000, 2'd3, 1'b0);

        // ---- 6: asynchronous reset mid-grant, pointer back to 0
        req = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        check_out("t6_async", 4'b0000, 2'd0, 1'b0);
        tick();
        check_out("t6_held", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        tick();
        check_out("t6_post", 4'b0001, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
